// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side constants and types.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Single-outstanding instruction-memory request/response bus.
interface if_fetch_unit_if;

    logic                          imem_req;
    logic [riscv_pkg::XLEN-1:0]    imem_addr;
    logic [riscv_pkg::XLEN-1:0]    imem_rdata;
    logic                          imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall, flush and synchronous reset.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // Flush beats stall; an unstalled cycle without a load becomes a bubble, PCs held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'h0;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            if (i_load) begin
                r_instr    <= i_instr;
                r_pc       <= i_pc;
                r_pc_plus4 <= i_pc + 32'd4;
                r_valid    <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, fetch FSM, hold buffer and IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PCSrcE,
    input  logic [31:0]            PCTargetE,
    input  logic                   StallF,
    input  logic                   StallD,
    input  logic                   FlushD,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            InstrD,
    output logic [31:0]            PCD,
    output logic [31:0]            PCPlus4D,
    output logic                   ValidD
);

    import riscv_pkg::*;

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pcf, w_pcf_nxt;
    logic [31:0]  r_tgt, w_tgt_nxt;
    logic [31:0]  r_hold_instr, w_hold_instr_nxt;
    logic         r_req_open, w_req_open_nxt;

    logic         w_req;
    logic         w_load;
    logic [31:0]  w_load_instr;
    logic [31:0]  w_target;
    logic [31:0]  w_pc_plus4;

    assign w_target   = PCTargetE & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_pcf + 32'd4;

    // The held instruction's PC is PCF itself, which stays put until the transfer.
    always_comb begin
        w_state_nxt      = r_state;
        w_pcf_nxt        = r_pcf;
        w_tgt_nxt        = r_tgt;
        w_hold_instr_nxt = r_hold_instr;
        w_req_open_nxt   = r_req_open;
        w_req            = 1'b0;
        w_load           = 1'b0;
        w_load_instr     = imem.imem_rdata;

        unique case (r_state)
            FETCH: begin
                w_req = !StallF || r_req_open;
                if (PCSrcE) begin
                    if (w_req && !imem.imem_valid) begin
                        w_state_nxt    = DROP;
                        w_tgt_nxt      = w_target;
                        w_req_open_nxt = 1'b1;
                    end else begin
                        w_pcf_nxt      = w_target;
                        w_req_open_nxt = 1'b0;
                    end
                end else if (w_req && imem.imem_valid) begin
                    w_req_open_nxt = 1'b0;
                    if (StallD) begin
                        w_hold_instr_nxt = imem.imem_rdata;
                        w_state_nxt      = HOLD;
                    end else begin
                        w_load    = 1'b1;
                        w_pcf_nxt = w_pc_plus4;
                    end
                end else begin
                    w_req_open_nxt = w_req;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    w_pcf_nxt   = w_target;
                    w_state_nxt = FETCH;
                end else if (!StallD) begin
                    w_load       = 1'b1;
                    w_load_instr = r_hold_instr;
                    w_pcf_nxt    = w_pc_plus4;
                    w_state_nxt  = FETCH;
                end
            end
            DROP: begin
                // Request must stay up at the old address until the stale response lands.
                w_req = 1'b1;
                if (PCSrcE) begin
                    w_tgt_nxt = w_target;
                end
                if (imem.imem_valid) begin
                    w_pcf_nxt      = PCSrcE ? w_target : r_tgt;
                    w_req_open_nxt = 1'b0;
                    w_state_nxt    = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pcf        <= RESET_PC;
            r_tgt        <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
            r_req_open   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pcf        <= w_pcf_nxt;
            r_tgt        <= w_tgt_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_req_open   <= w_req_open_nxt;
        end
    end

    assign imem.imem_req  = w_req && !rst;
    assign imem.imem_addr = r_pcf;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .i_stall    (StallD),
        .i_flush    (FlushD),
        .i_load     (w_load),
        .i_instr    (w_load_instr),
        .i_pc       (r_pcf),
        .o_instr    (InstrD),
        .o_pc       (PCD),
        .o_pc_plus4 (PCPlus4D),
        .o_valid    (ValidD)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic against a fetch model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    if_fetch_unit_if imem_bus ();

    if_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .imem      (imem_bus),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: PC, outstanding request, pending redirect, held instruction, IF/ID.
    bit          m_known = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_tgt = 32'h0;
    logic [31:0] m_held_instr = 32'h0;
    bit          m_open = 1'b0;
    bit          m_drop = 1'b0;
    bit          m_held = 1'b0;
    bit          e_valid = 1'b0;
    logic [31:0] e_instr = 32'h0;
    logic [31:0] e_pc = 32'h0;

    // Memory responder: latency in cycles after the first request cycle (0 = same cycle).
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    int          mem_lat = 0;
    int          lat_mode = 0;

    logic        s_req;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, want, $time);
        end
    endfunction

    task automatic cycle(input bit r, input bit sf, input bit sd, input bit fd, input bit ps,
                         input logic [31:0] tg);
        bit          exp_req;
        bit          v;
        bit          load;
        logic [31:0] ld_instr;
        logic [31:0] ld_pc;
        logic [31:0] tgt;
        tgt = tg & 32'hFFFF_FFFC;
        @(negedge clk);
        rst       = r;
        StallF    = sf;
        StallD    = sd;
        FlushD    = fd;
        PCSrcE    = ps;
        PCTargetE = tg;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        s_req  = imem_bus.imem_req;
        s_addr = imem_bus.imem_addr;
        v = 1'b0;
        if (s_req === 1'b1) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = 0;
                mem_lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            if (mem_cnt == mem_lat) begin
                v = 1'b1;
                imem_bus.imem_valid = 1'b1;
                imem_bus.imem_rdata = mem_word(s_addr);
            end
        end
        #1;
        exp_req = r ? 1'b0 : m_held ? 1'b0 : m_drop ? 1'b1 : (!sf || m_open);
        if (m_known) begin
            check("imem_req", {31'b0, s_req}, {31'b0, exp_req});
            check("imem_addr", s_addr, m_pc);
            check("ValidD", {31'b0, ValidD}, {31'b0, e_valid});
            check("InstrD", InstrD, e_valid ? e_instr : NOP);
            if (e_valid) begin
                check("PCD", PCD, e_pc);
                check("PCPlus4D", PCPlus4D, e_pc + 32'd4);
            end
        end
        @(posedge clk);
        if (r) begin
            m_known = 1'b1;
            m_pc    = 32'h0;
            m_open  = 1'b0;
            m_drop  = 1'b0;
            m_held  = 1'b0;
            e_valid = 1'b0;
            e_instr = NOP;
            e_pc    = 32'h0;
            mem_busy = 1'b0;
        end else begin
            load     = 1'b0;
            ld_instr = 32'h0;
            ld_pc    = 32'h0;
            if (m_drop) begin
                if (ps) m_tgt = tgt;
                if (v) begin
                    m_pc   = m_tgt;
                    m_drop = 1'b0;
                    m_open = 1'b0;
                end
            end else if (m_held) begin
                if (ps) begin
                    m_held = 1'b0;
                    m_pc   = tgt;
                end else if (!sd) begin
                    load     = 1'b1;
                    ld_instr = m_held_instr;
                    ld_pc    = m_pc;
                    m_held   = 1'b0;
                    m_pc     = m_pc + 32'd4;
                end
            end else if (ps) begin
                if (exp_req && !v) begin
                    m_drop = 1'b1;
                    m_tgt  = tgt;
                end else begin
                    m_pc   = tgt;
                    m_open = 1'b0;
                end
            end else if (exp_req && v) begin
                m_open = 1'b0;
                if (sd) begin
                    m_held       = 1'b1;
                    m_held_instr = mem_word(m_pc);
                end else begin
                    load     = 1'b1;
                    ld_instr = mem_word(m_pc);
                    ld_pc    = m_pc;
                    m_pc     = m_pc + 32'd4;
                end
            end else begin
                m_open = exp_req;
            end
            if (fd) begin
                e_valid = 1'b0;
                e_instr = NOP;
            end else if (!sd) begin
                if (load) begin
                    e_valid = 1'b1;
                    e_instr = ld_instr;
                    e_pc    = ld_pc;
                end else begin
                    e_valid = 1'b0;
                    e_instr = NOP;
                end
            end
            if (s_req === 1'b1 && v) mem_busy = 1'b0;
            else if (s_req === 1'b1 && mem_busy) mem_cnt++;
        end
        #1;
    endtask

    initial begin
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 32'h0;

        lat_mode = 0;
        cycle(1, 0, 0, 0, 0, 32'h0);
        cycle(1, 0, 0, 0, 0, 32'h0);
        check("rst_validd", {31'b0, ValidD}, 32'h0);
        check("rst_instrd", InstrD, 32'h0000_0013);
        check("rst_pcf", imem_bus.imem_addr, 32'h0);
        check("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);

        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 0, 32'h0);
            check("seq_pcd", PCD, 32'(4 * k));
            check("seq_validd", {31'b0, ValidD}, 32'h1);
        end

        lat_mode = 2;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 0, 32'h0);
            check("lat_req", {31'b0, s_req}, 32'h1);
            check("lat_addr", s_addr, 32'h10);
        end
        check("lat_pcd", PCD, 32'h10);
        check("lat_next_addr", imem_bus.imem_addr, 32'h14);

        lat_mode = 0;
        cycle(0, 0, 0, 0, 1, 32'h20);
        lat_mode = 1;
        cycle(0, 0, 0, 0, 1, 32'h100);
        check("drop_addr0", s_addr, 32'h20);
        cycle(0, 0, 0, 0, 0, 32'h0);
        check("drop_addr1", s_addr, 32'h20);
        check("drop_next_addr", imem_bus.imem_addr, 32'h100);
        check("drop_no_load", {31'b0, ValidD}, 32'h0);

        lat_mode = 0;
        cycle(0, 0, 0, 0, 1, 32'h40);
        cycle(0, 0, 1, 0, 0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            cycle(0, 0, 1, 0, 0, 32'h0);
            check("hold_req", {31'b0, s_req}, 32'h0);
            check("hold_validd", {31'b0, ValidD}, 32'h0);
        end
        cycle(0, 0, 0, 0, 0, 32'h0);
        check("release_pcd", PCD, 32'h40);
        check("release_validd", {31'b0, ValidD}, 32'h1);
        check("release_req", {31'b0, imem_bus.imem_req}, 32'h1);
        check("release_addr", imem_bus.imem_addr, 32'h44);

        cycle(0, 0, 1, 1, 1, 32'h103);
        check("flush_validd", {31'b0, ValidD}, 32'h0);
        check("flush_instrd", InstrD, 32'h0000_0013);
        check("flush_target", imem_bus.imem_addr, 32'h100);

        lat_mode = 2;
        cycle(0, 0, 0, 0, 1, 32'h200);
        check("dropent_req", {31'b0, s_req}, 32'h1);
        cycle(1, 0, 0, 0, 0, 32'h0);
        check("droprst_pcf", imem_bus.imem_addr, 32'h0);
        check("droprst_validd", {31'b0, ValidD}, 32'h0);

        lat_mode = 0;
        cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 0, 32'h0);
        check("wrap_pcd", PCD, 32'hFFFF_FFFC);
        check("wrap_pcplus4d", PCPlus4D, 32'h0);
        check("wrap_pcf", imem_bus.imem_addr, 32'h0);

        lat_mode = -1;
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
